// File: rtl/lcd_nibble_receiver.sv
// Responder for the 4-bit HD44780-style LCD bus: captures nibbles on E falling edges, rebuilds bytes, keeps a 2x16 char buffer.
// Latency: byte strobe 2 cycles after the iLCD change that drops E; buffer read data 1 cycle after rd_addr_i.
// Backpressure: none possible on the bus; nibbles arriving while busy are dropped and flagged in overrun_o.
module lcd_nibble_receiver #(
  parameter int unsigned BUSY_CYCLES  = 40,
  parameter int unsigned CLEAR_CYCLES = 1600   // must be >= 32 so the clear sweep finishes under busy
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_i,          // [7]=CE (ignored), [6]=RW, [5]=RS, [4]=E, [3:0]=data
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_is_data_o,
  output logic [4:0] cursor_o,
  output logic       busy_o,
  output logic       mode4_o,
  output logic       overrun_o
);

  localparam int unsigned MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    BLANK    = 8'h20;

  typedef enum logic [1:0] {S_INIT8, S_HIGH, S_LOW} state_t;

  // Chip enable carries no information for the receiver.
  logic unused_ce;
  assign unused_ce = lcd_i[7];

  logic [6:0]    lcd_q;
  logic          e_prev_q;
  state_t        state_q, state_d;
  logic [3:0]    hi_q, hi_d;
  logic          rs_lat_q, rs_lat_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          is_data_q, is_data_d;
  logic [4:0]    cursor_q, cursor_d;
  logic          inc_q, inc_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          mode4_q, mode4_d;
  logic          overrun_q, overrun_d;
  logic [5:0]    sweep_q, sweep_d;      // clear-sweep index; bit 5 set means idle
  logic [7:0]    rd_char_q;
  logic [7:0]    mem_q [32];

  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [7:0]    wr_dat;

  logic          fall;
  logic          rw;
  logic          rs;
  logic [3:0]    nib;
  logic          busy;
  logic [7:0]    rx_byte;

  assign fall    = e_prev_q & ~lcd_q[4];
  assign rw      = lcd_q[6];
  assign rs      = lcd_q[5];
  assign nib     = lcd_q[3:0];
  assign busy    = (busy_cnt_q != '0);
  assign rx_byte = {hi_q, nib};

  // Bus sampling register and E history for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_q    <= '0;
      e_prev_q <= 1'b0;
    end else begin
      lcd_q    <= lcd_i[6:0];
      e_prev_q <= lcd_q[4];
    end
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT8;
      hi_q       <= '0;
      rs_lat_q   <= 1'b0;
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      is_data_q  <= 1'b0;
      cursor_q   <= '0;
      inc_q      <= 1'b1;
      busy_cnt_q <= '0;
      mode4_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sweep_q    <= 6'd32;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      rs_lat_q   <= rs_lat_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      is_data_q  <= is_data_d;
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      busy_cnt_q <= busy_cnt_d;
      mode4_q    <= mode4_d;
      overrun_q  <= overrun_d;
      sweep_q    <= sweep_d;
    end
  end

  // Nibble FSM, byte decode, busy timing and buffer write selection.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    rs_lat_d   = rs_lat_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    is_data_d  = is_data_q;
    cursor_d   = cursor_q;
    inc_d      = inc_q;
    busy_cnt_d = busy ? (busy_cnt_q - CNT_ONE) : busy_cnt_q;
    mode4_d    = mode4_q;
    overrun_d  = overrun_q;
    sweep_d    = sweep_q[5] ? sweep_q : (sweep_q + 6'd1);
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_dat     = '0;

    // The clear sweep only runs while busy, so it never collides with a decoder write.
    if (!sweep_q[5]) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q[4:0];
      wr_dat  = BLANK;
    end

    if (fall && !rw) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else begin
        case (state_q)
          S_INIT8: begin
            if (nib == 4'h2) begin
              state_d = S_HIGH;
              mode4_d = 1'b1;
            end
          end
          S_HIGH: begin
            hi_d     = nib;
            rs_lat_d = rs;
            state_d  = S_LOW;
          end
          S_LOW: begin
            state_d = S_HIGH;
            // An RS change between halves means we lost sync: discard silently.
            if (rs == rs_lat_q) begin
              byte_vld_d = 1'b1;
              byte_d     = rx_byte;
              is_data_d  = rs;
              busy_cnt_d = BUSY_LD;
              if (rs) begin
                wr_en    = 1'b1;
                wr_addr  = cursor_q;
                wr_dat   = rx_byte;
                cursor_d = inc_q ? (cursor_q + 5'd1) : (cursor_q - 5'd1);
              end else begin
                casez (rx_byte)
                  8'b1???????: cursor_d = {rx_byte[6], rx_byte[3:0]};
                  8'b000001??: inc_d = rx_byte[1];
                  8'b0000001?: cursor_d = '0;
                  8'b00000001: begin
                    busy_cnt_d = CLEAR_LD;
                    sweep_d    = '0;
                    cursor_d   = '0;
                    inc_d      = 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
          default: state_d = S_INIT8;
        endcase
      end
    end
  end

  // Character buffer; reset leaves it blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= BLANK;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Registered read port; a same-cycle write to the same index returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_char_q <= '0;
    else     rd_char_q <= mem_q[rd_addr_i];
  end

  assign rd_char_o      = rd_char_q;
  assign byte_valid_o   = byte_vld_q;
  assign byte_o         = byte_q;
  assign byte_is_data_o = is_data_q;
  assign cursor_o       = cursor_q;
  assign busy_o         = busy;
  assign mode4_o        = mode4_q;
  assign overrun_o      = overrun_q;

endmodule
